// File: rtl/clock_ratio_monitor.sv
// rtl/clock_ratio_monitor.sv - half-period checker for a divided clock sampled in the clk_in domain
//
// Purpose:
//   Synchronizes a slow monitored clock (clk_mon) into clk_in. It measures the
//   number of clk_in cycles between successive clk_mon transitions of either
//   polarity and compares each measurement with EXP_HALF +/- TOL. It reports
//   lock, stall (no transition for 4*EXP_HALF cycles) and a sticky fault flag.
//
// Optional feature (macro CRM_DUTY_EN):
//   When defined, the module adds the high_len and low_len outputs. These hold
//   the last measured high and low phase lengths. Lock entry and lock hold then
//   also require |high_len - low_len| <= 1.
//
// Ports:
//   clk_in       in   sampling clock
//   rst_n        in   asynchronous active-low reset
//   clk_mon      in   monitored clock, asynchronous to clk_in
//   enable       in   monitor enable (level); low forces IDLE
//   err_clr      in   clears err_sticky (a same-cycle fault set wins)
//   half_period  out  last measured edge-to-edge distance, CNT_W bits
//   meas_valid   out  one-cycle strobe, half_period updated
//   locked       out  high in LOCKED
//   stall        out  high in FAULT when FAULT was entered by timeout
//   err_sticky   out  sticky fault flag
//   high_len     out  (CRM_DUTY_EN) last high phase length
//   low_len      out  (CRM_DUTY_EN) last low phase length

module clock_ratio_monitor #(
  parameter int EXP_HALF    = 2,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_mon,
  input  logic             enable,
  input  logic             err_clr,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             stall,
  output logic             err_sticky
`ifdef CRM_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  STALL_LIMIT = CNT_W'(4 * EXP_HALF);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    EXP_W       = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0]    TOL_W       = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

  // Synchronizer and history flop
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   mon_edge;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mon};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign mon_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

  // Measurement and tolerance
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;

  logic [CNT_W:0]   meas_wide;
  logic [CNT_W-1:0] meas;
  logic [CNT_W:0]   meas_ext;
  logic [CNT_W:0]   dev;
  logic             in_tol;
  logic             duty_ok;

  // cnt counts cycles since the last edge, so the distance is cnt+1.
  // The sum saturates so that a saturated counter still reports a large value.
  assign meas_wide = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign meas      = meas_wide[CNT_W] ? CNT_MAX : meas_wide[CNT_W-1:0];
  assign meas_ext  = {1'b0, meas};

  // The subtraction order follows the comparison, so neither branch wraps.
  always_comb begin
    dev = '0;
    if (meas_ext >= EXP_W) begin
      dev = meas_ext - EXP_W;
    end else begin
      dev = EXP_W - meas_ext;
    end
  end

  assign in_tol = (dev <= TOL_W);

`ifdef CRM_DUTY_EN
  // Duty check: candidate phase lengths include the measurement in flight
  logic             rising;
  logic [CNT_W-1:0] high_cand;
  logic [CNT_W-1:0] low_cand;
  logic [CNT_W-1:0] duty_dev;
  logic [CNT_W-1:0] high_len_n;
  logic [CNT_W-1:0] low_len_n;

  assign rising = mon_edge & sync_q[SYNC_STAGES-1];

  // A rising edge ends a low phase, and a falling edge ends a high phase.
  always_comb begin
    high_cand = high_len;
    low_cand  = low_len;
    if (rising) begin
      low_cand = meas;
    end else begin
      high_cand = meas;
    end
  end

  always_comb begin
    duty_dev = '0;
    if (high_cand >= low_cand) begin
      duty_dev = high_cand - low_cand;
    end else begin
      duty_dev = low_cand - high_cand;
    end
  end

  assign duty_ok = (duty_dev <= CNT_W'(1));
`else
  assign duty_ok = 1'b1;
`endif

  // Next-state logic
  logic [2:0]        state_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [GOOD_W-1:0] good_n;
  logic [GOOD_W-1:0] good_inc;
  logic              locked_n;
  logic              stall_n;
  logic              meas_valid_n;
  logic [CNT_W-1:0]  half_period_n;
  logic              err_set;
  logic              err_n;
  logic              timeout;

  // At timeout, an edge in the same cycle takes priority over the stall.
  assign timeout = (cnt >= STALL_LIMIT) && !mon_edge;

  // good_cnt holds at LOCK_COUNT when a duty violation blocks the lock.
  assign good_inc = (good_cnt < GOOD_TARGET) ? (good_cnt + 1'b1) : good_cnt;

  always_comb begin
    state_n       = state;
    good_n        = good_cnt;
    locked_n      = locked;
    stall_n       = stall;
    meas_valid_n  = 1'b0;
    half_period_n = half_period;
    err_set       = 1'b0;
`ifdef CRM_DUTY_EN
    high_len_n    = high_len;
    low_len_n     = low_len;
`endif

    if (mon_edge) begin
      cnt_n = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = cnt;
    end

    if (!enable) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      good_n   = '0;
      locked_n = 1'b0;
      stall_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n   = '0;
          state_n = ST_ARM;
        end

        // The first edge only restarts cnt, so the partial period is discarded.
        ST_ARM: begin
          if (mon_edge) begin
            state_n = ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (mon_edge) begin
            meas_valid_n  = 1'b1;
            half_period_n = meas;
`ifdef CRM_DUTY_EN
            high_len_n    = high_cand;
            low_len_n     = low_cand;
`endif
            if (in_tol) begin
              good_n = good_inc;
              if ((good_inc == GOOD_TARGET) && duty_ok) begin
                state_n  = ST_LOCKED;
                locked_n = 1'b1;
              end
            end else begin
              good_n = '0;
            end
          end else if (timeout) begin
            state_n = ST_FAULT;
            stall_n = 1'b1;
            good_n  = '0;
            err_set = 1'b1;
          end
        end

        ST_LOCKED: begin
          if (mon_edge) begin
            meas_valid_n  = 1'b1;
            half_period_n = meas;
`ifdef CRM_DUTY_EN
            high_len_n    = high_cand;
            low_len_n     = low_cand;
`endif
            if (!in_tol || !duty_ok) begin
              state_n  = ST_FAULT;
              locked_n = 1'b0;
              good_n   = '0;
              err_set  = 1'b1;
            end
          end else if (timeout) begin
            state_n  = ST_FAULT;
            locked_n = 1'b0;
            stall_n  = 1'b1;
            good_n   = '0;
            err_set  = 1'b1;
          end
        end

        // Recovery behaves like ARM: the edge restarts the measurement without a strobe.
        ST_FAULT: begin
          if (mon_edge) begin
            state_n = ST_MEASURE;
            stall_n = 1'b0;
            good_n  = '0;
          end
        end

        default: begin
          state_n  = ST_IDLE;
          cnt_n    = '0;
          good_n   = '0;
          locked_n = 1'b0;
          stall_n  = 1'b0;
        end
      endcase
    end

    // A fault set in the same cycle as err_clr takes priority over the clear.
    if (err_set) begin
      err_n = 1'b1;
    end else if (err_clr) begin
      err_n = 1'b0;
    end else begin
      err_n = err_sticky;
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      stall       <= 1'b0;
      meas_valid  <= 1'b0;
      half_period <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      good_cnt    <= good_n;
      locked      <= locked_n;
      stall       <= stall_n;
      meas_valid  <= meas_valid_n;
      half_period <= half_period_n;
      err_sticky  <= err_n;
    end
  end

`ifdef CRM_DUTY_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      high_len <= '0;
      low_len  <= '0;
    end else begin
      high_len <= high_len_n;
      low_len  <= low_len_n;
    end
  end
`endif

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb/tb_clock_ratio_monitor.sv - table-driven bench for clock_ratio_monitor

module tb_clock_ratio_monitor;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [1:0]  mon;
  logic        enable;
  logic        err_clr;
  logic [15:0] hp0, hp1;
  logic [1:0]  mv, lk, st, er;
`ifdef CRM_DUTY_EN
  logic [15:0] hl0, ll0, hl1, ll1;
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  clock_ratio_monitor #(.EXP_HALF(4), .TOL(0), .LOCK_COUNT(4), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .clk_mon(mon[0]), .enable(enable), .err_clr(err_clr),
    .half_period(hp0), .meas_valid(mv[0]), .locked(lk[0]), .stall(st[0]), .err_sticky(er[0])
`ifdef CRM_DUTY_EN
    , .high_len(hl0), .low_len(ll0)
`endif
  );

  clock_ratio_monitor #(.EXP_HALF(4), .TOL(1), .LOCK_COUNT(4), .CNT_W(16), .SYNC_STAGES(2)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .clk_mon(mon[1]), .enable(enable), .err_clr(err_clr),
    .half_period(hp1), .meas_valid(mv[1]), .locked(lk[1]), .stall(st[1]), .err_sticky(er[1])
`ifdef CRM_DUTY_EN
    , .high_len(hl1), .low_len(ll1)
`endif
  );

  // One row = toggle clk_mon[sel], then hold for len cycles.
  // n/hp: strobes seen in the window and the strobed value.
  // lk/err/st: levels at window end. st_at: first window cycle with stall high.
  typedef struct {
    int sel;
    int len;
    bit clr;
    int n;
    int hp;
    bit lk;
    bit err;
    int st_at;
    bit st;
  } row_t;

  row_t tbl[32];

  function automatic row_t mk(int sel, int len, bit clr, int n, int hp, bit lk, bit err, int st_at, bit st);
    row_t r;
    r.sel = sel; r.len = len; r.clr = clr; r.n = n; r.hp = hp;
    r.lk = lk; r.err = err; r.st_at = st_at; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int s, input string tag);
    chk($sformatf("%s dut%0d half_period", tag, s), s ? hp1 : hp0, 0);
    chk($sformatf("%s dut%0d meas_valid", tag, s), mv[s], 0);
    chk($sformatf("%s dut%0d locked", tag, s), lk[s], 0);
    chk($sformatf("%s dut%0d stall", tag, s), st[s], 0);
    chk($sformatf("%s dut%0d err_sticky", tag, s), er[s], 0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      int s, nstr, got_hp, st_at;
      s = tbl[r].sel;
      mon[s] = ~mon[s];
      nstr = 0; got_hp = 0; st_at = 0;
      for (int i = 1; i <= tbl[r].len; i++) begin
        @(negedge clk_in);
        if (mv[s]) begin
          nstr++;
          got_hp = s ? int'(hp1) : int'(hp0);
        end
        if (st[s] && st_at == 0) st_at = i;
        err_clr = (i == 2) ? tbl[r].clr : 1'b0;
      end
      chk($sformatf("row%0d strobes", r), nstr, tbl[r].n);
      if (tbl[r].n > 0) chk($sformatf("row%0d half_period", r), got_hp, tbl[r].hp);
      chk($sformatf("row%0d locked", r), lk[s], tbl[r].lk);
      chk($sformatf("row%0d err_sticky", r), er[s], tbl[r].err);
      chk($sformatf("row%0d stall_at", r), st_at, tbl[r].st_at);
      chk($sformatf("row%0d stall", r), st[s], tbl[r].st);
    end
  endtask

  initial begin
    bit dl;
    dl = !DUTY;
    // dut_a: EXP_HALF=4, TOL=0
    tbl[0]  = mk(0, 4, 0, 0, 0, 0, 0, 0, 0);   // ARM edge, no strobe
    tbl[1]  = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[2]  = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[3]  = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[4]  = mk(0, 4, 0, 1, 4, 1, 0, 0, 0);   // 5th edge locks
    tbl[5]  = mk(0, 5, 0, 1, 4, 1, 0, 0, 0);   // stretched phase
    tbl[6]  = mk(0, 4, 0, 1, 5, 0, 1, 0, 0);   // mismatch fault
    tbl[7]  = mk(0, 4, 0, 0, 0, 0, 1, 0, 0);   // FAULT -> MEASURE
    tbl[8]  = mk(0, 4, 0, 1, 4, 0, 1, 0, 0);
    tbl[9]  = mk(0, 4, 0, 1, 4, 0, 1, 0, 0);
    tbl[10] = mk(0, 4, 1, 1, 4, 0, 0, 0, 0);   // err_clr alone
    tbl[11] = mk(0, 4, 0, 1, 4, 1, 0, 0, 0);   // relock
    tbl[12] = mk(0, 3, 0, 1, 4, 1, 0, 0, 0);   // short phase
    tbl[13] = mk(0, 4, 1, 1, 3, 0, 1, 0, 0);   // fault + err_clr: set wins
    tbl[14] = mk(0, 4, 1, 0, 0, 0, 0, 0, 0);   // err_clr alone clears
    tbl[15] = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[16] = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[17] = mk(0, 4, 0, 1, 4, 0, 0, 0, 0);
    tbl[18] = mk(0, 4, 0, 1, 4, 1, 0, 0, 0);
    tbl[19] = mk(0, 24, 0, 1, 4, 0, 1, 20, 1); // static -> stall
    tbl[20] = mk(0, 4, 0, 0, 0, 0, 1, 1, 0);   // toggle clears stall
    tbl[21] = mk(0, 4, 0, 1, 4, 0, 1, 0, 0);
    tbl[22] = mk(0, 4, 0, 1, 4, 0, 1, 0, 0);
    tbl[23] = mk(0, 4, 0, 1, 4, 0, 1, 0, 0);
    tbl[24] = mk(0, 4, 0, 1, 4, 1, 1, 0, 0);
    // dut_b: TOL=1, phases 3/5
    tbl[25] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 5, 0, 1, 3, 0, 0, 0, 0);
    tbl[27] = mk(1, 3, 0, 1, 5, 0, 0, 0, 0);
    tbl[28] = mk(1, 5, 0, 1, 3, 0, 0, 0, 0);
    tbl[29] = mk(1, 3, 0, 1, 5, dl, 0, 0, 0);
    tbl[30] = mk(1, 5, 0, 1, 3, dl, 0, 0, 0);
    tbl[31] = mk(1, 3, 0, 1, 5, dl, 0, 0, 0);

    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; mon = 2'b00;
    repeat (3) @(negedge clk_in);
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_in);

    run_rows(0, 24);

    // Dropping enable while locked clears lock next edge, half_period and err_sticky hold.
    enable = 1'b0;
    @(negedge clk_in);
    chk("disable locked", lk[0], 0);
    chk("disable half_period", hp0, 4);
    chk("disable err_sticky", er[0], 1);
    chk("disable stall", st[0], 0);
    enable = 1'b1;
    repeat (2) @(negedge clk_in);
    mon[0] = ~mon[0];
    repeat (6) @(negedge clk_in);
    mon[0] = ~mon[0];
    repeat (2) @(negedge clk_in);
    // Asynchronous reset in mid-measurement
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "async reset");
    mon = 2'b00;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_zero(1, "post reset");

    run_rows(25, 31);
`ifdef CRM_DUTY_EN
    chk("duty high_len", hl1, 3);
    chk("duty low_len", ll1, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
